// File: rtl/rat_recovery_ctrl.sv
// Rename-history buffer with a youngest-first misprediction walk that restores a 2-wide RAT.
// Optional feature macro: RAT_RECOVERY_FREE_EN (also returns squashed allocations to the free list).
module rat_recovery_ctrl #(
  parameter int DEPTH       = 32,
  parameter int TAG_W       = 5,
  parameter int REG_SEL     = 5,
  parameter int PHY_REG_SEL = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ren_valid_1,
  input  logic                   ren_valid_2,
  input  logic                   ren_wr_1,
  input  logic                   ren_wr_2,
  input  logic [REG_SEL-1:0]     ren_dst_1,
  input  logic [REG_SEL-1:0]     ren_dst_2,
  input  logic [PHY_REG_SEL-1:0] ren_old_phy_1,
  input  logic [PHY_REG_SEL-1:0] ren_old_phy_2,
  input  logic [PHY_REG_SEL-1:0] ren_new_phy_1,
  input  logic [PHY_REG_SEL-1:0] ren_new_phy_2,
  output logic [TAG_W-1:0]       ren_tag_1,
  output logic [TAG_W-1:0]       ren_tag_2,
  output logic                   ren_stall,
  input  logic [1:0]             com_cnt,
  input  logic                   prmiss,
  input  logic [TAG_W-1:0]       prmiss_tag,
  output logic                   rst_valid_1,
  output logic                   rst_valid_2,
  output logic [REG_SEL-1:0]     rst_arch_1,
  output logic [REG_SEL-1:0]     rst_arch_2,
  output logic [PHY_REG_SEL-1:0] rst_phy_1,
  output logic [PHY_REG_SEL-1:0] rst_phy_2,
  output logic                   free_valid_1,
  output logic                   free_valid_2,
  output logic [PHY_REG_SEL-1:0] free_phy_1,
  output logic [PHY_REG_SEL-1:0] free_phy_2,
  output logic                   walk_busy,
  output logic                   recover_done,
  output logic [TAG_W:0]         count,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = TAG_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] remain_q, remain_d;

  logic                   ent_wr_q   [DEPTH];
  logic                   ent_wr_d   [DEPTH];
  logic [REG_SEL-1:0]     ent_arch_q [DEPTH];
  logic [REG_SEL-1:0]     ent_arch_d [DEPTH];
  logic [PHY_REG_SEL-1:0] ent_old_q  [DEPTH];
  logic [PHY_REG_SEL-1:0] ent_old_d  [DEPTH];

  logic                   rst_valid_1_q, rst_valid_1_d, rst_valid_2_q, rst_valid_2_d;
  logic [REG_SEL-1:0]     rst_arch_1_q, rst_arch_1_d, rst_arch_2_q, rst_arch_2_d;
  logic [PHY_REG_SEL-1:0] rst_phy_1_q, rst_phy_1_d, rst_phy_2_q, rst_phy_2_d;
  logic                   recover_done_q, recover_done_d;

`ifdef RAT_RECOVERY_FREE_EN
  logic [PHY_REG_SEL-1:0] ent_new_q [DEPTH];
  logic [PHY_REG_SEL-1:0] ent_new_d [DEPTH];
  logic                   free_valid_1_q, free_valid_1_d, free_valid_2_q, free_valid_2_d;
  logic [PHY_REG_SEL-1:0] free_phy_1_q, free_phy_1_d, free_phy_2_q, free_phy_2_d;
`endif

  logic [TAG_W-1:0] tail_idx, tail_idx_p1, pop_idx_1, pop_idx_2, squash_lo;
  logic [PTR_W-1:0] room, walk_left, live_after, com_eff;
  logic             walk_go, acc_1, acc_2;
  logic [1:0]       pop_cnt;

  assign tail_idx    = tail_q[TAG_W-1:0];
  assign tail_idx_p1 = tail_idx + TAG_W'(1);
  assign pop_idx_1   = tail_idx - TAG_W'(1);
  assign pop_idx_2   = tail_idx - TAG_W'(2);
  // Entries younger than the branch; the branch is live, so this never exceeds DEPTH-1.
  assign squash_lo   = tail_idx - prmiss_tag - TAG_W'(1);

  assign count     = tail_q - head_q;
  assign room      = PTR_W'(DEPTH) - count;
  assign ren_tag_1 = tail_idx;
  assign ren_tag_2 = tail_idx_p1;

  // Rename handshake: slot k is taken on a clock edge iff ren_valid_k & ~ren_stall
  // (slot 2 additionally needs slot 1); while ren_stall is high every slot input is ignored.
  assign ren_stall = (state_q != S_IDLE) | prmiss | (room < PTR_W'(2));
  assign acc_1     = ren_valid_1 & ~ren_stall;
  assign acc_2     = acc_1 & ren_valid_2;

  assign walk_busy = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    remain_d       = remain_q;
    ent_wr_d       = ent_wr_q;
    ent_arch_d     = ent_arch_q;
    ent_old_d      = ent_old_q;
    walk_go        = 1'b0;
    walk_left      = '0;
    pop_cnt        = 2'd0;
    rst_valid_1_d  = 1'b0;
    rst_valid_2_d  = 1'b0;
    rst_arch_1_d   = '0;
    rst_arch_2_d   = '0;
    rst_phy_1_d    = '0;
    rst_phy_2_d    = '0;
    recover_done_d = 1'b0;
`ifdef RAT_RECOVERY_FREE_EN
    ent_new_d      = ent_new_q;
    free_valid_1_d = 1'b0;
    free_valid_2_d = 1'b0;
    free_phy_1_d   = '0;
    free_phy_2_d   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (prmiss) begin
          // First pop happens on the miss edge so restores appear the very next cycle.
          walk_go   = 1'b1;
          walk_left = PTR_W'(squash_lo);
          if (squash_lo == '0) begin
            state_d        = S_DONE;
            recover_done_d = 1'b1;
          end else begin
            state_d = S_WALK;
          end
        end
      end
      S_WALK: begin
        if (remain_q == '0) begin
          state_d        = S_DONE;
          recover_done_d = 1'b1;
        end else begin
          walk_go   = 1'b1;
          walk_left = remain_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (walk_go) begin
      if (walk_left >= PTR_W'(2))     pop_cnt = 2'd2;
      else if (walk_left != '0)       pop_cnt = 2'd1;
      else                            pop_cnt = 2'd0;
      remain_d = walk_left - PTR_W'(pop_cnt);
      tail_d   = tail_q - PTR_W'(pop_cnt);
    end

    // Port 2 carries the older entry so a write-2-wins RAT ends on the oldest mapping.
    if (pop_cnt != 2'd0) begin
      rst_valid_1_d = ent_wr_q[pop_idx_1];
      rst_arch_1_d  = ent_arch_q[pop_idx_1];
      rst_phy_1_d   = ent_old_q[pop_idx_1];
`ifdef RAT_RECOVERY_FREE_EN
      free_valid_1_d = ent_wr_q[pop_idx_1];
      free_phy_1_d   = ent_new_q[pop_idx_1];
`endif
    end
    if (pop_cnt == 2'd2) begin
      rst_valid_2_d = ent_wr_q[pop_idx_2];
      rst_arch_2_d  = ent_arch_q[pop_idx_2];
      rst_phy_2_d   = ent_old_q[pop_idx_2];
`ifdef RAT_RECOVERY_FREE_EN
      free_valid_2_d = ent_wr_q[pop_idx_2];
      free_phy_2_d   = ent_new_q[pop_idx_2];
`endif
    end

    if (acc_1) begin
      ent_wr_d[tail_idx]   = ren_wr_1;
      ent_arch_d[tail_idx] = ren_dst_1;
      ent_old_d[tail_idx]  = ren_old_phy_1;
`ifdef RAT_RECOVERY_FREE_EN
      ent_new_d[tail_idx]  = ren_new_phy_1;
`endif
      tail_d = tail_q + (acc_2 ? PTR_W'(2) : PTR_W'(1));
    end
    if (acc_2) begin
      ent_wr_d[tail_idx_p1]   = ren_wr_2;
      ent_arch_d[tail_idx_p1] = ren_dst_2;
      ent_old_d[tail_idx_p1]  = ren_old_phy_2;
`ifdef RAT_RECOVERY_FREE_EN
      ent_new_d[tail_idx_p1]  = ren_new_phy_2;
`endif
    end

    // Commit retires from the old end; clamp so an over-commit saturates count at zero.
    live_after = tail_q - PTR_W'(pop_cnt) - head_q;
    com_eff    = (PTR_W'(com_cnt) > live_after) ? live_after : PTR_W'(com_cnt);
    head_d     = head_q + com_eff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      remain_q       <= '0;
      rst_valid_1_q  <= 1'b0;
      rst_valid_2_q  <= 1'b0;
      rst_arch_1_q   <= '0;
      rst_arch_2_q   <= '0;
      rst_phy_1_q    <= '0;
      rst_phy_2_q    <= '0;
      recover_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_wr_q[i]   <= 1'b0;
        ent_arch_q[i] <= '0;
        ent_old_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      remain_q       <= remain_d;
      rst_valid_1_q  <= rst_valid_1_d;
      rst_valid_2_q  <= rst_valid_2_d;
      rst_arch_1_q   <= rst_arch_1_d;
      rst_arch_2_q   <= rst_arch_2_d;
      rst_phy_1_q    <= rst_phy_1_d;
      rst_phy_2_q    <= rst_phy_2_d;
      recover_done_q <= recover_done_d;
      ent_wr_q       <= ent_wr_d;
      ent_arch_q     <= ent_arch_d;
      ent_old_q      <= ent_old_d;
    end
  end

  assign rst_valid_1  = rst_valid_1_q;
  assign rst_valid_2  = rst_valid_2_q;
  assign rst_arch_1   = rst_arch_1_q;
  assign rst_arch_2   = rst_arch_2_q;
  assign rst_phy_1    = rst_phy_1_q;
  assign rst_phy_2    = rst_phy_2_q;
  assign recover_done = recover_done_q;

`ifdef RAT_RECOVERY_FREE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_valid_1_q <= 1'b0;
      free_valid_2_q <= 1'b0;
      free_phy_1_q   <= '0;
      free_phy_2_q   <= '0;
      for (int i = 0; i < DEPTH; i++) ent_new_q[i] <= '0;
    end else begin
      free_valid_1_q <= free_valid_1_d;
      free_valid_2_q <= free_valid_2_d;
      free_phy_1_q   <= free_phy_1_d;
      free_phy_2_q   <= free_phy_2_d;
      ent_new_q      <= ent_new_d;
    end
  end

  assign free_valid_1 = free_valid_1_q;
  assign free_valid_2 = free_valid_2_q;
  assign free_phy_1   = free_phy_1_q;
  assign free_phy_2   = free_phy_2_q;
`else
  // The free list restores itself from its own checkpoint in this build.
  logic unused_new_phy;
  assign unused_new_phy = ^{ren_new_phy_1, ren_new_phy_2};
  assign free_valid_1   = 1'b0;
  assign free_valid_2   = 1'b0;
  assign free_phy_1     = '0;
  assign free_phy_2     = '0;
`endif

  a_commit_within_count: assert property (@(posedge clk) disable iff (reset)
    PTR_W'(com_cnt) <= count);
  a_single_recovery: assert property (@(posedge clk) disable iff (reset)
    prmiss |-> (state_q == S_IDLE));

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Bench for rat_recovery_ctrl: directed scenarios plus random traffic, checked against a
// queue model of the live history and a per-cycle schedule of expected recovery outputs.
`timescale 1ns/1ps
module tb_rat_recovery_ctrl;
  localparam int DEPTH = 32;
  localparam int TAG_W = 5;
  localparam int RW    = 5;
  localparam int PW    = 6;
`ifdef RAT_RECOVERY_FREE_EN
  localparam bit FREE_ON = 1'b1;
`else
  localparam bit FREE_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             ren_valid_1, ren_valid_2, ren_wr_1, ren_wr_2;
  logic [RW-1:0]    ren_dst_1, ren_dst_2;
  logic [PW-1:0]    ren_old_phy_1, ren_old_phy_2, ren_new_phy_1, ren_new_phy_2;
  logic [TAG_W-1:0] ren_tag_1, ren_tag_2, prmiss_tag;
  logic             ren_stall, prmiss;
  logic [1:0]       com_cnt;
  logic             rst_valid_1, rst_valid_2, free_valid_1, free_valid_2;
  logic [RW-1:0]    rst_arch_1, rst_arch_2;
  logic [PW-1:0]    rst_phy_1, rst_phy_2, free_phy_1, free_phy_2;
  logic             walk_busy, recover_done;
  logic [TAG_W:0]   count;
  logic [1:0]       unused_dbg_state;

  rat_recovery_ctrl dut (
    .clk(clk), .reset(reset),
    .ren_valid_1(ren_valid_1), .ren_valid_2(ren_valid_2),
    .ren_wr_1(ren_wr_1), .ren_wr_2(ren_wr_2),
    .ren_dst_1(ren_dst_1), .ren_dst_2(ren_dst_2),
    .ren_old_phy_1(ren_old_phy_1), .ren_old_phy_2(ren_old_phy_2),
    .ren_new_phy_1(ren_new_phy_1), .ren_new_phy_2(ren_new_phy_2),
    .ren_tag_1(ren_tag_1), .ren_tag_2(ren_tag_2), .ren_stall(ren_stall),
    .com_cnt(com_cnt), .prmiss(prmiss), .prmiss_tag(prmiss_tag),
    .rst_valid_1(rst_valid_1), .rst_valid_2(rst_valid_2),
    .rst_arch_1(rst_arch_1), .rst_arch_2(rst_arch_2),
    .rst_phy_1(rst_phy_1), .rst_phy_2(rst_phy_2),
    .free_valid_1(free_valid_1), .free_valid_2(free_valid_2),
    .free_phy_1(free_phy_1), .free_phy_2(free_phy_2),
    .walk_busy(walk_busy), .recover_done(recover_done), .count(count),
    .dbg_state(unused_dbg_state)
  );

  // ---------------- model / scoreboard ----------------
  typedef struct packed {
    logic wr; logic [RW-1:0] arch; logic [PW-1:0] oldp; logic [PW-1:0] newp; logic [TAG_W-1:0] tag;
  } ent_t;
  typedef struct packed {
    logic active; logic done; logic [1:0] pops;
    logic v1; logic [RW-1:0] a1; logic [PW-1:0] p1; logic f1; logic [PW-1:0] fp1;
    logic v2; logic [RW-1:0] a2; logic [PW-1:0] p2; logic f2; logic [PW-1:0] fp2;
  } rec_t;

  ent_t hist[$];   // live history, oldest first
  rec_t exp_q[$];  // expected recovery outputs, one record per upcoming cycle
  rec_t cur;       // record expected in the current cycle
  int   tail_m;    // absolute tail, mod 2*DEPTH
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [PW-1:0] rat_x3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Squashed entries are restored youngest first, two per cycle, then one done cycle.
  task automatic start_walk(input int p);
    ent_t sq[$];
    ent_t e;
    rec_t r;
    for (int i = hist.size() - 1; i > p; i--) sq.push_back(hist[i]);
    while (sq.size() > 0) begin
      r = '0; r.active = 1'b1;
      e = sq.pop_front();
      r.pops = 2'd1; r.v1 = e.wr; r.a1 = e.arch; r.p1 = e.oldp; r.f1 = FREE_ON & e.wr; r.fp1 = e.newp;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        r.pops = 2'd2; r.v2 = e.wr; r.a2 = e.arch; r.p2 = e.oldp; r.f2 = FREE_ON & e.wr; r.fp2 = e.newp;
      end
      exp_q.push_back(r);
    end
    r = '0; r.active = 1'b1; r.done = 1'b1;
    exp_q.push_back(r);
  endtask

  function automatic int pend_pops();
    int s = 0;
    foreach (exp_q[i]) s += int'(exp_q[i].pops);
    return s;
  endfunction

  // One clock: compare at negedge, advance the model at posedge, return 1ns later.
  task automatic cycle();
    logic stall_m;
    int   idx;
    ent_t e;
    @(negedge clk);
    stall_m = cur.active | prmiss | ((DEPTH - hist.size()) < 2);
    check("count", 32'(count), hist.size());
    check("ren_tag_1", 32'(ren_tag_1), tail_m % DEPTH);
    check("ren_tag_2", 32'(ren_tag_2), (tail_m + 1) % DEPTH);
    check("ren_stall", 32'(ren_stall), 32'(stall_m));
    check("walk_busy", 32'(walk_busy), 32'(cur.active));
    check("recover_done", 32'(recover_done), 32'(cur.done));
    check("rst_valid_1", 32'(rst_valid_1), 32'(cur.v1));
    check("rst_valid_2", 32'(rst_valid_2), 32'(cur.v2));
    if (cur.v1) begin
      check("rst_arch_1", 32'(rst_arch_1), 32'(cur.a1));
      check("rst_phy_1", 32'(rst_phy_1), 32'(cur.p1));
    end
    if (cur.v2) begin
      check("rst_arch_2", 32'(rst_arch_2), 32'(cur.a2));
      check("rst_phy_2", 32'(rst_phy_2), 32'(cur.p2));
    end
    check("free_valid_1", 32'(free_valid_1), 32'(cur.f1));
    check("free_valid_2", 32'(free_valid_2), 32'(cur.f2));
    if (cur.f1) check("free_phy_1", 32'(free_phy_1), 32'(cur.fp1));
    if (cur.f2) check("free_phy_2", 32'(free_phy_2), 32'(cur.fp2));
    if (rst_valid_1 && rst_arch_1 == RW'(3)) rat_x3 = rst_phy_1;
    if (rst_valid_2 && rst_arch_2 == RW'(3)) rat_x3 = rst_phy_2;
    @(posedge clk);
    if (!stall_m && ren_valid_1) begin
      e.wr = ren_wr_1; e.arch = ren_dst_1; e.oldp = ren_old_phy_1; e.newp = ren_new_phy_1;
      e.tag = TAG_W'(tail_m % DEPTH);
      hist.push_back(e); tail_m = (tail_m + 1) % (2 * DEPTH);
      if (ren_valid_2) begin
        e.wr = ren_wr_2; e.arch = ren_dst_2; e.oldp = ren_old_phy_2; e.newp = ren_new_phy_2;
        e.tag = TAG_W'(tail_m % DEPTH);
        hist.push_back(e); tail_m = (tail_m + 1) % (2 * DEPTH);
      end
    end
    if (prmiss && !cur.active) begin
      idx = -1;
      foreach (hist[i]) if (hist[i].tag == prmiss_tag) idx = i;
      if (idx >= 0) start_walk(idx);
    end
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '0;
    repeat (int'(cur.pops)) begin
      void'(hist.pop_back());
      tail_m = (tail_m + 2 * DEPTH - 1) % (2 * DEPTH);
    end
    repeat (int'(com_cnt)) if (hist.size() > 0) void'(hist.pop_front());
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    ren_valid_1 = 0; ren_valid_2 = 0; ren_wr_1 = 0; ren_wr_2 = 0;
    ren_dst_1 = '0; ren_dst_2 = '0; ren_old_phy_1 = '0; ren_old_phy_2 = '0;
    ren_new_phy_1 = '0; ren_new_phy_2 = '0;
    com_cnt = 2'd0; prmiss = 1'b0; prmiss_tag = '0;
  endtask

  task automatic set_slot1(input logic wr, input int d, input int o, input int n);
    ren_valid_1 = 1'b1; ren_wr_1 = wr; ren_dst_1 = RW'(d); ren_old_phy_1 = PW'(o); ren_new_phy_1 = PW'(n);
  endtask

  task automatic set_slot2(input logic wr, input int d, input int o, input int n);
    ren_valid_2 = 1'b1; ren_wr_2 = wr; ren_dst_2 = RW'(d); ren_old_phy_2 = PW'(o); ren_new_phy_2 = PW'(n);
  endtask

  task automatic rand_pair(input bit both);
    set_slot1($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
    if (both || $urandom_range(0, 1) == 1)
      set_slot2($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    hist.delete(); exp_q.delete(); cur = '0; tail_m = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin idle_in(); cycle(); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int p;
    int allowed;
    int k;
    rat_x3 = '0;
    reset = 1'b1;
    cur = '0;
    tail_m = 0;
    idle_in();
    do_reset();
    run_idle(1);

    // Fill with 15 pairs, then one commit of two.
    for (int i = 0; i < 15; i++) begin idle_in(); rand_pair(1'b1); cycle(); end
    run_idle(1);
    idle_in(); com_cnt = 2'd2; cycle();
    run_idle(1);

    // Branch at tag 3 squashes two x3 renames; x3 must end on p3.
    do_reset();
    idle_in(); set_slot1(1, 7, 7, 42); set_slot2(1, 1, 1, 33); cycle();
    idle_in(); set_slot1(1, 2, 2, 34); set_slot2(0, 0, 0, 35); cycle();
    idle_in(); set_slot1(1, 3, 3, 40); set_slot2(1, 3, 40, 41); cycle();
    rat_x3 = PW'(41);
    idle_in(); prmiss = 1'b1; prmiss_tag = TAG_W'(3); cycle();
    run_idle(3);
    check("x3_final", 32'(rat_x3), 32'd3);

    // Miss on the youngest entry: nothing to squash.
    idle_in(); set_slot1(1, 9, 9, 50); cycle();
    idle_in(); prmiss = 1'b1; prmiss_tag = hist[hist.size() - 1].tag; cycle();
    run_idle(3);

    // Five squashed entries while committing one per walk cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin idle_in(); rand_pair(1'b1); cycle(); end
    idle_in(); prmiss = 1'b1; prmiss_tag = TAG_W'(2); cycle();
    for (int i = 0; i < 3; i++) begin idle_in(); com_cnt = 2'd1; cycle(); end
    run_idle(3);

    // Pointer wrap: 31 live, retire 20, rename 10 across index 31 -> 0, miss before the wrap.
    do_reset();
    for (int i = 0; i < 15; i++) begin idle_in(); rand_pair(1'b1); cycle(); end
    idle_in(); rand_pair(1'b0); ren_valid_2 = 1'b0; cycle();
    for (int i = 0; i < 10; i++) begin idle_in(); com_cnt = 2'd2; cycle(); end
    for (int i = 0; i < 5; i++) begin idle_in(); rand_pair(1'b1); cycle(); end
    idle_in(); prmiss = 1'b1; prmiss_tag = TAG_W'(29); cycle();
    run_idle(9);

    // Reset in the middle of a walk clears everything immediately.
    do_reset();
    for (int i = 0; i < 3; i++) begin idle_in(); rand_pair(1'b1); cycle(); end
    idle_in(); prmiss = 1'b1; prmiss_tag = TAG_W'(0); cycle();
    idle_in(); cycle();
    reset = 1'b1;
    #1;
    check("async_rst_valid_1", 32'(rst_valid_1), 32'd0);
    check("async_walk_busy", 32'(walk_busy), 32'd0);
    check("async_count", 32'(count), 32'd0);
    do_reset();
    run_idle(2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      if ($urandom_range(0, 3) != 0) rand_pair(1'b0);
      if (!cur.active && hist.size() > 0 && $urandom_range(0, 15) == 0) begin
        p = $urandom_range(0, hist.size() - 1);
        prmiss = 1'b1;
        prmiss_tag = hist[p].tag;
        k = $urandom_range(0, 2);
        com_cnt = 2'((k < p) ? k : p);
      end else begin
        allowed = hist.size() - pend_pops();
        k = $urandom_range(0, 2);
        com_cnt = 2'((k < allowed) ? k : allowed);
      end
      cycle();
    end
    run_idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
